ddr_download_arbiter: RTL

- Owns the single DDR3 (Avalon-style) port in clk_sys.
- Shares it between the HPS ROM download stream and two burst-read clients: rd0 = graphics/tile fetch, rd1 = program/sample fetch.
- Packs 16-bit ioctl words into 64-bit masked writes and drives ioctl_wait back-pressure.
- Sequences fixed-length read bursts and arbitrates round-robin between the read clients.

---
 rtl/ddr_download_arbiter.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/ddr_download_arbiter.sv
// DDR3 port owner: packs 16-bit download words into masked 64-bit writes and
// round-robins fixed-length read bursts between two clients. Optional: DL_CHECKSUM_EN.
module ddr_download_arbiter #(
   parameter int BURST_LEN = 4,
   parameter int DL_ADDR_W = 25
) (
   input  logic                 clk_sys,
   input  logic                 sreset_n,
   input  logic                 dl_cs,
   input  logic                 dl_wr,
   input  logic [DL_ADDR_W-1:0] dl_addr,
   input  logic [15:0]          dl_data,
   output logic                 dl_wait,
   input  logic                 rd0_req,
   input  logic [31:0]          rd0_addr,
   output logic                 rd0_ack,
   output logic                 rd0_valid,
   output logic                 rd0_done,
   input  logic                 rd1_req,
   input  logic [31:0]          rd1_addr,
   output logic                 rd1_ack,
   output logic                 rd1_valid,
   output logic                 rd1_done,
   output logic [63:0]          rd_data,
   output logic                 ddr_rd,
   output logic                 ddr_wr,
   output logic [31:0]          ddr_addr,
   output logic [7:0]           ddr_burstcnt,
   output logic [7:0]           ddr_be,
   output logic [63:0]          ddr_din,
   input  logic [63:0]          ddr_dout,
   input  logic                 ddr_valid,
   input  logic                 ddr_wait
`ifdef DL_CHECKSUM_EN
   ,
   output logic [31:0]          dl_checksum
`endif
);

   localparam int LINE_W = DL_ADDR_W - 3;

   typedef enum logic [1:0] {IDLE, WRITE, RCMD, RDATA} state_t;

   state_t state, state_next;

   logic [63:0]       buf_data;
   logic [7:0]        buf_mask;
   logic [LINE_W-1:0] buf_line;
   logic              flush_pend;
   logic              dl_cs_d;
   logic              rr_ptr;
   logic              sel;
   logic [28:0]       rd_line;
   logic [7:0]        beat_cnt;

   logic [1:0]        lane;
   logic [LINE_W-1:0] word_line;
   logic              buf_used;
   logic              line_conflict;
   logic              dl_accept;
   logic              cs_fall;
   logic              flush_now;
   logic              wr_accept;
   logic              rd_accept;
   logic              grant;
   logic              grant_sel;
   logic              beat_take;
   logic              last_beat;
   logic              unused_addr_bits;

   assign unused_addr_bits = ^{dl_addr[0], rd0_addr[2:0], rd1_addr[2:0]};

   assign lane          = dl_addr[2:1];
   assign word_line     = dl_addr[DL_ADDR_W-1:3];
   assign buf_used      = |buf_mask;
   // A word for another line stalls in the same cycle so the host re-presents it after the flush.
   assign line_conflict = dl_wr && buf_used && (word_line != buf_line);
   assign dl_wait       = flush_pend || line_conflict;
   assign dl_accept     = dl_wr && !dl_wait;
   assign cs_fall       = dl_cs_d && !dl_cs;
   // The dl_cs falling edge is seen here directly so a read cannot slip in ahead of its flush.
   assign flush_now     = flush_pend || (cs_fall && (buf_used || dl_accept));
   assign wr_accept     = (state == WRITE) && !ddr_wait;
   assign rd_accept     = (state == RCMD) && !ddr_wait;
   assign grant         = (state == IDLE) && !flush_now && !dl_cs && (rd0_req || rd1_req);
   assign grant_sel     = (rd0_req && rd1_req) ? rr_ptr : rd1_req;
   assign beat_take     = (state == RDATA) && ddr_valid;
   assign last_beat     = beat_take && (beat_cnt == 8'(BURST_LEN - 1));

   always_ff @(posedge clk_sys) begin
      if (!sreset_n) begin
         state      <= IDLE;
         buf_data   <= '0;
         buf_mask   <= '0;
         buf_line   <= '0;
         flush_pend <= 1'b0;
         dl_cs_d    <= 1'b0;
         rr_ptr     <= 1'b0;
         sel        <= 1'b0;
         rd_line    <= '0;
         beat_cnt   <= '0;
         rd_data    <= '0;
         rd0_valid  <= 1'b0;
         rd1_valid  <= 1'b0;
         rd0_done   <= 1'b0;
         rd1_done   <= 1'b0;
      end else begin
         state   <= state_next;
         dl_cs_d <= dl_cs;

         if (wr_accept) begin
            flush_pend <= 1'b0;
            buf_mask   <= '0;
         end else if (line_conflict || (dl_accept && lane == 2'd3) ||
                      (cs_fall && (buf_used || dl_accept))) begin
            flush_pend <= 1'b1;
         end

         if (dl_accept) begin
            buf_data[{lane, 4'b0000} +: 16] <= dl_data;
            buf_mask[{lane, 1'b0} +: 2]     <= 2'b11;
            if (!buf_used)
               buf_line <= word_line;
         end

         if (grant) begin
            sel     <= grant_sel;
            rd_line <= grant_sel ? rd1_addr[31:3] : rd0_addr[31:3];
         end

         // The pointer names the client that wins the next tie.
         if (rd_accept) begin
            rr_ptr   <= ~sel;
            beat_cnt <= '0;
         end else if (beat_take) begin
            beat_cnt <= beat_cnt + 8'd1;
         end

         if (beat_take)
            rd_data <= ddr_dout;
         rd0_valid <= beat_take && !sel;
         rd1_valid <= beat_take && sel;
         rd0_done  <= last_beat && !sel;
         rd1_done  <= last_beat && sel;
      end
   end

   always_comb begin
      state_next   = state;
      ddr_rd       = 1'b0;
      ddr_wr       = 1'b0;
      ddr_addr     = '0;
      ddr_burstcnt = 8'd1;
      ddr_be       = '0;
      ddr_din      = '0;
      rd0_ack      = 1'b0;
      rd1_ack      = 1'b0;
      case (state)
         IDLE: begin
            if (flush_now)
               state_next = WRITE;
            else if (grant)
               state_next = RCMD;
         end
         WRITE: begin
            ddr_wr   = 1'b1;
            ddr_addr = 32'({buf_line, 3'b000});
            ddr_be   = buf_mask;
            ddr_din  = buf_data;
            if (!ddr_wait)
               state_next = IDLE;
         end
         RCMD: begin
            ddr_rd       = 1'b1;
            ddr_burstcnt = 8'(BURST_LEN);
            ddr_addr     = {rd_line, 3'b000};
            if (!ddr_wait) begin
               rd0_ack    = !sel;
               rd1_ack    = sel;
               state_next = RDATA;
            end
         end
         RDATA: begin
            if (last_beat)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

`ifdef DL_CHECKSUM_EN
   logic [31:0] checksum;

   assign dl_checksum = checksum;

   // A word accepted on the first cycle of a download still belongs to the new sum.
   always_ff @(posedge clk_sys) begin
      if (!sreset_n)
         checksum <= '0;
      else if (dl_cs && !dl_cs_d)
         checksum <= dl_accept ? {16'h0000, dl_data} : 32'h0;
      else if (dl_accept)
         checksum <= checksum + {16'h0000, dl_data};
   end
`endif

endmodule
